// File: rtl/tmr_pkg.sv
// Shared types for the triple-modular-redundancy voter.
// FSM state encoding, lane id type and the "no lane" id.
package tmr_pkg;

   typedef enum logic [1:0] {
      ST_OK,
      ST_SUSPECT,
      ST_FAULT,
      ST_FAIL
   } tmr_state_e;

   typedef logic [1:0] lane_id_t;

   localparam lane_id_t LANE_NONE = 2'd3;

endpackage

// File: rtl/tmr_majority.sv
// Combinational bitwise 2-of-3 majority with per-lane disagree flags.
// Ports: r0/r1/r2 lanes in; voted majority out; dis[k]=1 when lane k != voted.
module tmr_majority #(
   parameter int W = 1
) (
   input  logic [W-1:0] r0,
   input  logic [W-1:0] r1,
   input  logic [W-1:0] r2,
   output logic [W-1:0] voted,
   output logic [2:0]   dis
);

   assign voted = (r0 & r1) | (r0 & r2) | (r1 & r2);

   assign dis = {r2 != voted, r1 != voted, r0 != voted};

endmodule

// File: rtl/tmr_voter.sv
// TMR voter: registered majority vote, faulty-lane localisation and sticky
// fault/fail status. Optional assertions under macro TMR_VOTER_SVA_EN.
// Ports: clk, rst (sync, active low), in_valid, r0/r1/r2, clear ->
//   out_valid, voted, mismatch, fault, fault_lane, fail, mm_count.
module tmr_voter #(
   parameter int W       = 1,
   parameter int PERSIST = 3,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [W-1:0]     r0,
   input  logic [W-1:0]     r1,
   input  logic [W-1:0]     r2,
   input  logic             clear,
   output logic             out_valid,
   output logic [W-1:0]     voted,
   output logic             mismatch,
   output logic             fault,
   output logic [1:0]       fault_lane,
   output logic             fail,
   output logic [CNT_W-1:0] mm_count
);

   import tmr_pkg::*;

   localparam int PW = $clog2(PERSIST + 1);

   logic [W-1:0] vote;
   logic [2:0]   dis;
   logic [1:0]   ndis;
   lane_id_t     dlane;

   tmr_state_e   state_q, state_d;
   lane_id_t     lane_q, lane_d;
   logic [PW-1:0] cnt_q, cnt_d;
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] voted_q, voted_d;
   logic         mismatch_q, mismatch_d;
   logic         fault_q, fault_d;
   lane_id_t     fault_lane_q, fault_lane_d;
   logic         fail_q, fail_d;
   logic [CNT_W-1:0] mm_q, mm_d;

   tmr_majority #(.W(W)) u_maj (
      .r0    (r0),
      .r1    (r1),
      .r2    (r2),
      .voted (vote),
      .dis   (dis)
   );

   assign ndis = 2'(dis[0]) + 2'(dis[1]) + 2'(dis[2]);

   // Lane id is only meaningful when exactly one lane disagrees.
   always_comb begin
      dlane = LANE_NONE;
      if (ndis == 2'd1) begin
         unique case (1'b1)
            dis[0]: dlane = 2'd0;
            dis[1]: dlane = 2'd1;
            dis[2]: dlane = 2'd2;
            default: dlane = LANE_NONE;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      lane_d       = lane_q;
      cnt_d        = cnt_q;
      out_valid_d  = in_valid;
      voted_d      = voted_q;
      mismatch_d   = mismatch_q;
      fault_d      = fault_q;
      fault_lane_d = fault_lane_q;
      fail_d       = fail_q;
      mm_d         = mm_q;

      if (in_valid) begin
         voted_d    = vote;
         mismatch_d = |dis;
      end

      // A sample arriving with clear still reaches the output but is
      // neither counted nor seen by the FSM.
      if (clear) begin
         state_d      = ST_OK;
         lane_d       = LANE_NONE;
         cnt_d        = '0;
         fault_d      = 1'b0;
         fault_lane_d = LANE_NONE;
         fail_d       = 1'b0;
         mm_d         = '0;
      end else if (in_valid) begin
         if (ndis != 2'd0 && mm_q != '1) begin
            mm_d = mm_q + CNT_W'(1);
         end
         if (ndis >= 2'd2) begin
            fail_d  = 1'b1;
            state_d = ST_FAIL;
            cnt_d   = '0;
         end else begin
            unique case (state_q)
               ST_OK: begin
                  if (ndis == 2'd1) begin
                     if (PERSIST == 1) begin
                        state_d      = ST_FAULT;
                        fault_d      = 1'b1;
                        fault_lane_d = dlane;
                     end else begin
                        state_d = ST_SUSPECT;
                        lane_d  = dlane;
                        cnt_d   = PW'(1);
                     end
                  end
               end
               ST_SUSPECT: begin
                  if (ndis == 2'd0) begin
                     state_d = ST_OK;
                     cnt_d   = '0;
                  end else if (dlane == lane_q) begin
                     cnt_d = cnt_q + PW'(1);
                     if (cnt_q == PW'(PERSIST - 1)) begin
                        state_d      = ST_FAULT;
                        fault_d      = 1'b1;
                        fault_lane_d = lane_q;
                     end
                  end else begin
                     lane_d = dlane;
                     cnt_d  = PW'(1);
                  end
               end
               ST_FAULT: ;
               ST_FAIL:  ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_OK;
         lane_q       <= LANE_NONE;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         voted_q      <= '0;
         mismatch_q   <= 1'b0;
         fault_q      <= 1'b0;
         fault_lane_q <= LANE_NONE;
         fail_q       <= 1'b0;
         mm_q         <= '0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         voted_q      <= voted_d;
         mismatch_q   <= mismatch_d;
         fault_q      <= fault_d;
         fault_lane_q <= fault_lane_d;
         fail_q       <= fail_d;
         mm_q         <= mm_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign voted      = voted_q;
   assign mismatch   = mismatch_q;
   assign fault      = fault_q;
   assign fault_lane = fault_lane_q;
   assign fail       = fail_q;
   assign mm_count   = mm_q;

`ifdef TMR_VOTER_SVA_EN
   a_lane_iff_fault: assert property (@(posedge clk) disable iff (!rst)
      (fault_lane_q != LANE_NONE) == fault_q);

   a_fault_sticky: assert property (@(posedge clk) disable iff (!rst)
      $fell(fault_q) |-> $past(clear) || !$past(rst));

   a_fail_sticky: assert property (@(posedge clk) disable iff (!rst)
      $fell(fail_q) |-> $past(clear) || !$past(rst));

   a_mm_no_wrap: assert property (@(posedge clk) disable iff (!rst)
      ($past(mm_q) == '1 && mm_q != '1)
      |-> $past(clear) || !$past(rst));

   a_valid_lat: assert property (@(posedge clk) disable iff (!rst)
      $past(rst) |-> out_valid_q == $past(in_valid));

   // With one-bit lanes two lanes cannot both differ from the majority.
   if (W == 1) begin : g_w1
      a_no_fail_w1: assert property (@(posedge clk) disable iff (!rst)
         !fail_q);
   end
`endif

endmodule

// File: tb/tb_tmr_voter.sv
// Bench for tmr_voter: spec-level model checked every cycle on two
// configurations, plus literal expectations at key points.
module tb_tmr_voter;

   localparam int S_OK  = 0;
   localparam int S_SUS = 1;
   localparam int S_FLT = 2;
   localparam int S_FAI = 3;

   typedef struct {
      bit       ov;
      bit [3:0] v;
      bit       mm;
      bit       flt;
      bit [1:0] fl;
      bit       fail;
      int       mmc;
      int       st;
      int       sl;
      int       sc;
   } mdl_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [3:0] r0, r1, r2;
   logic       clear;

   logic       a_ov, a_mm, a_f, a_fail;
   logic [3:0] a_v;
   logic [1:0] a_fl;
   logic [7:0] a_mc;

   logic       b_ov, b_mm, b_f, b_fail;
   logic [3:0] b_v;
   logic [1:0] b_fl;
   logic [1:0] b_mc;

   int n_chk  = 0;
   int n_pass = 0;
   bit started = 0;
   mdl_t ma, mb;

   tmr_voter #(.W(4), .PERSIST(3), .CNT_W(8)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .r0(r0), .r1(r1), .r2(r2), .clear(clear),
      .out_valid(a_ov), .voted(a_v), .mismatch(a_mm),
      .fault(a_f), .fault_lane(a_fl), .fail(a_fail),
      .mm_count(a_mc)
   );

   tmr_voter #(.W(4), .PERSIST(1), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .r0(r0), .r1(r1), .r2(r2), .clear(clear),
      .out_valid(b_ov), .voted(b_v), .mismatch(b_mm),
      .fault(b_f), .fault_lane(b_fl), .fail(b_fail),
      .mm_count(b_mc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic mdl_t step(mdl_t m, bit rn, bit iv,
                                 bit [3:0] a, bit [3:0] b,
                                 bit [3:0] c, bit clr,
                                 int per, int cmax);
      mdl_t n;
      int nd;
      int k;
      bit [3:0] v;
      n = m;
      nd = 0;
      k = 3;
      if (!rn) begin
         n = '{default: 0};
         n.fl = 2'd3;
         n.sl = 3;
         return n;
      end
      n.ov = iv;
      if (iv) begin
         for (int i = 0; i < 4; i++)
            v[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
         if (a != v) begin nd++; k = 0; end
         if (b != v) begin nd++; k = 1; end
         if (c != v) begin nd++; k = 2; end
         n.v  = v;
         n.mm = (nd > 0);
      end
      if (clr) begin
         n.st = S_OK; n.sc = 0; n.sl = 3; n.mmc = 0;
         n.flt = 0; n.fl = 2'd3; n.fail = 0;
         return n;
      end
      if (!iv) return n;
      if (nd > 0 && n.mmc < cmax) n.mmc++;
      if (nd >= 2) begin
         n.fail = 1;
         n.st = S_FAI;
         return n;
      end
      case (n.st)
         S_OK: if (nd == 1) begin
            if (per == 1) begin
               n.st = S_FLT; n.flt = 1; n.fl = 2'(k);
            end else begin
               n.st = S_SUS; n.sl = k; n.sc = 1;
            end
         end
         S_SUS: begin
            if (nd == 0) begin
               n.st = S_OK; n.sc = 0;
            end else if (k == n.sl) begin
               n.sc++;
               if (n.sc >= per) begin
                  n.st = S_FLT; n.flt = 1; n.fl = 2'(k);
               end
            end else begin
               n.sl = k; n.sc = 1;
            end
         end
         default: ;
      endcase
      return n;
   endfunction

   always @(posedge clk) begin
      ma = step(ma, rst, in_valid, r0, r1, r2, clear, 3, 255);
      mb = step(mb, rst, in_valid, r0, r1, r2, clear, 1, 3);
      started = 1;
   end

   task automatic cmp(string nm, mdl_t m, logic ov, logic [3:0] v,
                      logic mm, logic f, logic [1:0] fl,
                      logic fa, logic [7:0] mc);
      n_chk++;
      if (ov === m.ov && v === m.v && mm === m.mm && f === m.flt &&
          fl === m.fl && fa === m.fail && mc === 8'(m.mmc))
         n_pass++;
      else
         $display("FAIL model_%s t=%0t got ov=%b v=%h mm=%b f=%b fl=%0d fail=%b cnt=%0d want ov=%b v=%h mm=%b f=%b fl=%0d fail=%b cnt=%0d",
                  nm, $time, ov, v, mm, f, fl, fa, mc,
                  m.ov, m.v, m.mm, m.flt, m.fl, m.fail, m.mmc);
   endtask

   always @(negedge clk) begin
      if (started) begin
         cmp("a", ma, a_ov, a_v, a_mm, a_f, a_fl, a_fail, a_mc);
         cmp("b", mb, b_ov, b_v, b_mm, b_f, b_fl, b_fail,
             {6'd0, b_mc});
      end
   end

   task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h want=%h", nm, got, exp);
   endtask

   task automatic cyc(logic iv, logic [3:0] a, logic [3:0] b,
                      logic [3:0] c, logic clr = 1'b0);
      in_valid = iv;
      r0 = a;
      r1 = b;
      r2 = c;
      clear = clr;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 1'b0;
      r0 = '0; r1 = '0; r2 = '0;
      clear = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ov", 8'(a_ov), 8'd0);
      chk("rst_fl", 8'(a_fl), 8'd3);
      chk("rst_mc", a_mc, 8'd0);
      rst = 1'b1;

      repeat (10) cyc(1, 4'hA, 4'hA, 4'hA);
      chk("agree_v", 8'(a_v), 8'hA);
      chk("agree_mm", 8'(a_mm), 8'd0);
      chk("agree_mc", a_mc, 8'd0);
      chk("agree_fl", 8'(a_fl), 8'd3);

      cyc(1, 4'hA, 4'h5, 4'hA);
      chk("l1_b_fault", 8'(b_f), 8'd1);
      chk("l1_b_fl", 8'(b_fl), 8'd1);
      cyc(1, 4'hA, 4'h5, 4'hA);
      chk("l1_a_f2", 8'(a_f), 8'd0);
      cyc(1, 4'hA, 4'h5, 4'hA);
      chk("l1_v", 8'(a_v), 8'hA);
      chk("l1_fault", 8'(a_f), 8'd1);
      chk("l1_fl", 8'(a_fl), 8'd1);
      chk("l1_mc", a_mc, 8'd3);

      cyc(0, 4'h0, 4'h0, 4'h0, 1'b1);
      chk("clr_f", 8'(a_f), 8'd0);
      chk("clr_fl", 8'(a_fl), 8'd3);
      chk("clr_mc", a_mc, 8'd0);

      cyc(1, 4'hA, 4'hA, 4'h3);
      cyc(1, 4'hA, 4'hA, 4'h3);
      cyc(1, 4'hA, 4'hA, 4'hA);
      cyc(1, 4'hA, 4'hA, 4'h3);
      cyc(1, 4'hA, 4'hA, 4'h3);
      chk("sus_f", 8'(a_f), 8'd0);
      chk("sus_mc", a_mc, 8'd4);
      cyc(1, 4'hA, 4'hA, 4'h3);
      chk("sus_f3", 8'(a_f), 8'd1);
      chk("sus_fl3", 8'(a_fl), 8'd2);

      cyc(0, 4'h0, 4'h0, 4'h0, 1'b1);
      cyc(1, 4'h1, 4'h2, 4'h4);
      chk("fail_v", 8'(a_v), 8'h0);
      chk("fail_mm", 8'(a_mm), 8'd1);
      chk("fail_set", 8'(a_fail), 8'd1);
      chk("fail_b", 8'(b_fail), 8'd1);
      repeat (5) cyc(1, 4'hA, 4'hA, 4'hA);
      chk("fail_hold", 8'(a_fail), 8'd1);
      cyc(1, 4'hA, 4'h5, 4'hA, 1'b1);
      chk("clrv_v", 8'(a_v), 8'hA);
      chk("clrv_mm", 8'(a_mm), 8'd1);
      chk("clrv_fail", 8'(a_fail), 8'd0);
      chk("clrv_mc", a_mc, 8'd0);
      chk("clrv_fl", 8'(a_fl), 8'd3);

      repeat (5) cyc(1, 4'hF, 4'hA, 4'hA);
      chk("sat_b", 8'(b_mc), 8'd3);
      chk("sat_a", a_mc, 8'd5);
      chk("sat_fl", 8'(a_fl), 8'd0);
      cyc(0, 4'h0, 4'h0, 4'h0);
      chk("idle_ov", 8'(a_ov), 8'd0);
      chk("idle_v", 8'(a_v), 8'hA);
      chk("idle_mm", 8'(a_mm), 8'd1);
      chk("idle_mc", a_mc, 8'd5);

      cyc(0, 4'h0, 4'h0, 4'h0, 1'b1);
      cyc(1, 4'hA, 4'hA, 4'h3);
      cyc(1, 4'hA, 4'hA, 4'h3);
      rst = 1'b0;
      cyc(1, 4'hA, 4'hA, 4'h3);
      cyc(1, 4'hA, 4'hA, 4'h3);
      chk("inrst_ov", 8'(a_ov), 8'd0);
      chk("inrst_v", 8'(a_v), 8'h0);
      chk("inrst_mc", a_mc, 8'd0);
      chk("inrst_fl", 8'(a_fl), 8'd3);
      rst = 1'b1;
      cyc(1, 4'hA, 4'hA, 4'h3);
      chk("prst_f1", 8'(a_f), 8'd0);
      cyc(1, 4'hA, 4'hA, 4'h3);
      chk("prst_f2", 8'(a_f), 8'd0);
      cyc(1, 4'hA, 4'hA, 4'h3);
      chk("prst_f3", 8'(a_f), 8'd1);
      chk("prst_mc", a_mc, 8'd3);
      cyc(0, 4'h0, 4'h0, 4'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
